// File: rtl/float_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | float_addsub_pipe                                                    |
// | Three-stage pipelined floating-point add/subtract with global stall: |
// | S1 unpack/compare/align, S2 mantissa add/sub, S3 normalise/round.    |
// | Macro FLOAT_ADDSUB_RNE_EN: defined -> round-to-nearest-even,         |
// | undefined -> truncate.                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module float_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_sum,
  output logic                 out_ovf,
  output logic                 out_unf
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int FW  = MAN_W + 4;        // hidden | mantissa | guard | round | sticky
  localparam int SW  = FW + 1;
  localparam int IEW = EXP_W + 2;
  localparam int LZW = $clog2(FW);
  localparam logic signed [IEW-1:0] EXP_MAX  = IEW'((1 << EXP_W) - 1);
  localparam logic signed [IEW-1:0] EXP_ZERO = '0;
`ifdef FLOAT_ADDSUB_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  // Stage registers
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_sign_q, s1_sign_d;
  logic                  s1_sub_q, s1_sub_d;
  logic [EXP_W-1:0]      s1_exp_q, s1_exp_d;
  logic [FW-1:0]         s1_big_q, s1_big_d;
  logic [FW-1:0]         s1_small_q, s1_small_d;
  logic                  s1_byp_q, s1_byp_d;
  logic [W-1:0]          s1_byp_word_q, s1_byp_word_d;

  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_sign_q, s2_sign_d;
  logic signed [IEW-1:0] s2_exp_q, s2_exp_d;
  logic [SW-1:0]         s2_sum_q, s2_sum_d;
  logic                  s2_byp_q, s2_byp_d;
  logic [W-1:0]          s2_byp_word_q, s2_byp_word_d;

  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          out_sum_q, out_sum_d;
  logic                  out_ovf_q, out_ovf_d;
  logic                  out_unf_q, out_unf_d;

  logic advance;

  assign advance   = ~out_valid_q | out_ready;
  assign in_ready  = advance & ~rst;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;

  // ---------------- S1: unpack, magnitude compare, align ----------------
  logic             b_sign, a_zero, b_zero, a_ge_b, big_sign;
  logic [EXP_W-1:0] big_exp, exp_diff;
  logic [FW-1:0]    big_man, small_raw, small_al;
  logic [2*FW-1:0]  small_ext;

  always_comb begin
    b_sign = in_b[W-1] ^ in_op;
    a_zero = (in_a[W-2:MAN_W] == '0);
    b_zero = (in_b[W-2:MAN_W] == '0);
    a_ge_b = (in_a[W-2:0] >= in_b[W-2:0]);
    if (a_ge_b) begin
      big_sign  = in_a[W-1];
      big_exp   = in_a[W-2:MAN_W];
      big_man   = {1'b1, in_a[MAN_W-1:0], 3'b000};
      small_raw = {1'b1, in_b[MAN_W-1:0], 3'b000};
      exp_diff  = in_a[W-2:MAN_W] - in_b[W-2:MAN_W];
    end else begin
      big_sign  = b_sign;
      big_exp   = in_b[W-2:MAN_W];
      big_man   = {1'b1, in_b[MAN_W-1:0], 3'b000};
      small_raw = {1'b1, in_a[MAN_W-1:0], 3'b000};
      exp_diff  = in_b[W-2:MAN_W] - in_a[W-2:MAN_W];
    end
    // Lower half of the extended shift collects the bits lost to the sticky.
    small_ext = {small_raw, {FW{1'b0}}} >> exp_diff;
    if (32'(exp_diff) >= 32'(FW - 1)) begin
      small_al = {{(FW-1){1'b0}}, 1'b1};
    end else begin
      small_al = small_ext[2*FW-1:FW] | {{(FW-1){1'b0}}, |small_ext[FW-1:0]};
    end

    s1_valid_d    = s1_valid_q;
    s1_sign_d     = s1_sign_q;
    s1_sub_d      = s1_sub_q;
    s1_exp_d      = s1_exp_q;
    s1_big_d      = s1_big_q;
    s1_small_d    = s1_small_q;
    s1_byp_d      = s1_byp_q;
    s1_byp_word_d = s1_byp_word_q;
    if (advance) begin
      s1_valid_d = in_valid;
      s1_sign_d  = big_sign;
      s1_sub_d   = in_a[W-1] ^ b_sign;
      s1_exp_d   = big_exp;
      s1_big_d   = big_man;
      s1_small_d = small_al;
      s1_byp_d   = a_zero | b_zero;
      if (a_zero && b_zero) begin
        s1_byp_word_d = '0;
      end else if (a_zero) begin
        s1_byp_word_d = {b_sign, in_b[W-2:0]};
      end else begin
        s1_byp_word_d = in_a;
      end
    end
  end

  // ---------------- S2: signed mantissa add / subtract ----------------
  always_comb begin
    s2_valid_d    = s2_valid_q;
    s2_sign_d     = s2_sign_q;
    s2_exp_d      = s2_exp_q;
    s2_sum_d      = s2_sum_q;
    s2_byp_d      = s2_byp_q;
    s2_byp_word_d = s2_byp_word_q;
    if (advance) begin
      s2_valid_d    = s1_valid_q;
      s2_sign_d     = s1_sign_q;
      s2_exp_d      = {2'b00, s1_exp_q};
      s2_byp_d      = s1_byp_q;
      s2_byp_word_d = s1_byp_word_q;
      // Larger magnitude is always s1_big, so the difference never borrows.
      if (s1_sub_q) begin
        s2_sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
      end else begin
        s2_sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
      end
    end
  end

  // ---------------- S3: normalise, round, pack, flag ----------------
  logic [LZW-1:0]        lz;
  logic [FW-1:0]         norm_man;
  logic signed [IEW-1:0] norm_exp, rnd_exp;
  logic                  round_up, frac_carry;
  logic [MAN_W-1:0]      frac;
  logic [W-1:0]          res_sum;
  logic                  res_ovf, res_unf;

  always_comb begin
    lz = '0;
    for (int i = 0; i < FW; i++) begin
      if (s2_sum_q[i]) lz = LZW'(FW - 1 - i);
    end
    if (s2_sum_q[SW-1]) begin
      norm_man = s2_sum_q[SW-1:1] | {{(FW-1){1'b0}}, s2_sum_q[0]};
      norm_exp = s2_exp_q + IEW'(1);
    end else begin
      norm_man = s2_sum_q[FW-1:0] << lz;
      norm_exp = s2_exp_q - IEW'(lz);
    end

    round_up = RNE & norm_man[2] & (norm_man[1] | norm_man[0] | norm_man[3]);
    {frac_carry, frac} = {1'b0, norm_man[FW-2:3]} + {{MAN_W{1'b0}}, round_up};
    // A carry out of the fraction leaves frac at zero: 1.111..1 + ulp = 10.000..0
    rnd_exp = frac_carry ? (norm_exp + IEW'(1)) : norm_exp;

    res_ovf = 1'b0;
    res_unf = 1'b0;
    if (s2_byp_q) begin
      res_sum = s2_byp_word_q;
    end else if (!norm_man[FW-1]) begin
      res_sum = '0;
    end else if (rnd_exp >= EXP_MAX) begin
      res_sum = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end else if (rnd_exp <= EXP_ZERO) begin
      res_sum = '0;
      res_unf = 1'b1;
    end else begin
      res_sum = {s2_sign_q, rnd_exp[EXP_W-1:0], frac};
    end

    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;
    if (advance) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_sum_d = res_sum;
        out_ovf_d = res_ovf;
        out_unf_d = res_unf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_exp_q      <= '0;
      s1_big_q      <= '0;
      s1_small_q    <= '0;
      s1_byp_q      <= 1'b0;
      s1_byp_word_q <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
      s2_byp_q      <= 1'b0;
      s2_byp_word_q <= '0;
      out_valid_q   <= 1'b0;
      out_sum_q     <= '0;
      out_ovf_q     <= 1'b0;
      out_unf_q     <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_sub_q      <= s1_sub_d;
      s1_exp_q      <= s1_exp_d;
      s1_big_q      <= s1_big_d;
      s1_small_q    <= s1_small_d;
      s1_byp_q      <= s1_byp_d;
      s1_byp_word_q <= s1_byp_word_d;
      s2_valid_q    <= s2_valid_d;
      s2_sign_q     <= s2_sign_d;
      s2_exp_q      <= s2_exp_d;
      s2_sum_q      <= s2_sum_d;
      s2_byp_q      <= s2_byp_d;
      s2_byp_word_q <= s2_byp_word_d;
      out_valid_q   <= out_valid_d;
      out_sum_q     <= out_sum_d;
      out_ovf_q     <= out_ovf_d;
      out_unf_q     <= out_unf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_float_addsub_pipe                                                 |
// | FP16 vector table driven through a scoreboard, plus stall, latency  |
// | and reset-in-flight sequences.                                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_float_addsub_pipe;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] sum;
    logic        ovf;
    logic        unf;
  } vec_t;

  localparam int NV = 19;
`ifdef FLOAT_ADDSUB_RNE_EN
  localparam logic [15:0] R_3C01_1000 = 16'h3C02;
  localparam logic [15:0] R_3BFF_0C00 = 16'h3C00;
`else
  localparam logic [15:0] R_3C01_1000 = 16'h3C01;
  localparam logic [15:0] R_3BFF_0C00 = 16'h3BFF;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_op, out_valid, out_ready, out_ovf, out_unf;
  logic [15:0] in_a, in_b, out_sum;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   lat;
  vec_t sb[$];
  vec_t tbl[NV];
  vec_t mon_e;

  always #5 clk = ~clk;

  float_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: compares the head of the scoreboard every cycle a result is shown.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_out: got out_sum 0x%0h, expected no result", out_sum);
      end else begin
        mon_e = sb[0];
        check($sformatf("out_sum(%h%s%h)", mon_e.a, mon_e.op ? "-" : "+", mon_e.b),
              32'(out_sum), 32'(mon_e.sum));
        check("out_ovf", 32'(out_ovf), 32'(mon_e.ovf));
        check("out_unf", 32'(out_unf), 32'(mon_e.unf));
        if (out_ready) void'(sb.pop_front());
        else check("in_ready_stall", 32'(in_ready), 32'd0);
      end
    end
  end

  task automatic send(input vec_t v);
    int guard;
    in_a     = v.a;
    in_b     = v.b;
    in_op    = v.op;
    in_valid = 1'b1;
    guard    = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end else begin
      sb.push_back(v);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic measure_latency(input string name);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(name, 32'(lat), 32'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{a:16'h3C00, b:16'h4000, op:1'b0, sum:16'h4200,      ovf:1'b0, unf:1'b0};
    tbl[1]  = '{a:16'h3C00, b:16'hC000, op:1'b0, sum:16'hBC00,      ovf:1'b0, unf:1'b0};
    tbl[2]  = '{a:16'h3C00, b:16'h3C00, op:1'b1, sum:16'h0000,      ovf:1'b0, unf:1'b0};
    tbl[3]  = '{a:16'h7BFF, b:16'h7BFF, op:1'b0, sum:16'h7C00,      ovf:1'b1, unf:1'b0};
    tbl[4]  = '{a:16'h0400, b:16'h0401, op:1'b1, sum:16'h0000,      ovf:1'b0, unf:1'b1};
    tbl[5]  = '{a:16'h3C01, b:16'h1000, op:1'b0, sum:R_3C01_1000,   ovf:1'b0, unf:1'b0};
    tbl[6]  = '{a:16'h0000, b:16'h3C00, op:1'b0, sum:16'h3C00,      ovf:1'b0, unf:1'b0};
    tbl[7]  = '{a:16'h0000, b:16'h4000, op:1'b1, sum:16'hC000,      ovf:1'b0, unf:1'b0};
    tbl[8]  = '{a:16'h8000, b:16'h0000, op:1'b0, sum:16'h0000,      ovf:1'b0, unf:1'b0};
    tbl[9]  = '{a:16'h4000, b:16'h4000, op:1'b0, sum:16'h4400,      ovf:1'b0, unf:1'b0};
    tbl[10] = '{a:16'h4500, b:16'h3C00, op:1'b1, sum:16'h4400,      ovf:1'b0, unf:1'b0};
    tbl[11] = '{a:16'hC200, b:16'hC200, op:1'b0, sum:16'hC600,      ovf:1'b0, unf:1'b0};
    tbl[12] = '{a:16'h3C00, b:16'hBC00, op:1'b1, sum:16'h4000,      ovf:1'b0, unf:1'b0};
    tbl[13] = '{a:16'hF800, b:16'hF800, op:1'b0, sum:16'hFC00,      ovf:1'b1, unf:1'b0};
    tbl[14] = '{a:16'h6000, b:16'h1000, op:1'b0, sum:16'h6000,      ovf:1'b0, unf:1'b0};
    tbl[15] = '{a:16'h3C00, b:16'h3BFF, op:1'b1, sum:16'h1000,      ovf:1'b0, unf:1'b0};
    tbl[16] = '{a:16'h3BFF, b:16'h0C00, op:1'b0, sum:R_3BFF_0C00,   ovf:1'b0, unf:1'b0};
    tbl[17] = '{a:16'h0800, b:16'h07FF, op:1'b1, sum:16'h0000,      ovf:1'b0, unf:1'b1};
    tbl[18] = '{a:16'h0800, b:16'h0400, op:1'b1, sum:16'h0400,      ovf:1'b0, unf:1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_out_unf",   32'(out_unf),   32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Single transaction into an idle pipe: 1.0 + 2.0
    send(tbl[0]);
    measure_latency("latency_first");
    drain();

    // Whole table back-to-back, then again under random backpressure
    for (int i = 0; i < NV; i++) send(tbl[i]);
    drain();
    fork
      begin
        for (int i = 0; i < NV; i++) send(tbl[i]);
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Six-pair stream with a four-cycle stall from the first result
    fork
      begin
        for (int i = 0; i < 6; i++) send(tbl[i]);
      end
      begin
        int g = 0;
        while (!out_valid && g < 50) begin
          @(posedge clk);
          #1;
          g++;
        end
        out_ready = 1'b0;
        repeat (4) begin
          #2;
          check("stream_in_ready_low", 32'(in_ready), 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three pairs in flight
    send(tbl[3]);
    send(tbl[4]);
    send(tbl[5]);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sum",   32'(out_sum),   32'd0);
    check("midrst_out_ovf",   32'(out_ovf),   32'd0);
    check("midrst_out_unf",   32'(out_unf),   32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    send(tbl[10]);
    measure_latency("latency_after_rst");
    drain();

    repeat (10) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
